// File: rtl/bp_be_issue_scoreboard.sv
// Issue-stage RAW/WAW hazard scoreboard in front of the integer register file.
// Tracks fixed-latency writes in a short shift pipe and long-latency writes in per-register busy bits.
module bp_be_issue_scoreboard #(
    parameter int reg_addr_width_p = 5,
    parameter int pipe_depth_p     = 4,
    parameter int long_max_p       = 4
) (
    input  logic                        clk_i,
    input  logic                        reset_n_i,
    input  logic                        issue_v_i,
    input  logic                        issue_rs1_v_i,
    input  logic [reg_addr_width_p-1:0] issue_rs1_addr_i,
    input  logic                        issue_rs2_v_i,
    input  logic [reg_addr_width_p-1:0] issue_rs2_addr_i,
    input  logic                        issue_rd_v_i,
    input  logic [reg_addr_width_p-1:0] issue_rd_addr_i,
    input  logic                        issue_rd_long_i,
    output logic                        issue_ready_o,
    output logic                        rs1_r_v_o,
    output logic                        rs2_r_v_o,
    input  logic                        long_wb_v_i,
    input  logic [reg_addr_width_p-1:0] long_wb_addr_i,
    input  logic                        flush_i,
    output logic [3:0]                  long_cnt_o
);

    localparam int NumRegs   = 2 ** reg_addr_width_p;
    localparam int NumStages = pipe_depth_p - 1;

    typedef logic [reg_addr_width_p-1:0] addr_t;
    localparam addr_t X0 = '0;

    logic [NumStages:1] r_pipe_v;
    addr_t              r_pipe_addr [1:NumStages];
    logic [NumRegs-1:0] r_busy;
    logic [3:0]         r_long_cnt;

    logic               w_rs1_pipe, w_rs2_pipe, w_rd_pipe;
    logic               w_rs1_busy, w_rs2_busy, w_rd_busy;
    logic               w_wb_clr;
    logic               w_rd_nz, w_rd_long_v, w_rd_fix_v;
    logic               w_raw, w_waw, w_long_waw, w_full;
    logic               w_ready, w_accept;
    logic               w_long_push, w_fix_push;
    logic [NumRegs-1:0] w_busy_nxt;

    // Match each operand against every valid in-flight fixed write.
    always_comb begin
        w_rs1_pipe = 1'b0;
        w_rs2_pipe = 1'b0;
        w_rd_pipe  = 1'b0;
        for (int k = 1; k <= NumStages; k++) begin
            w_rs1_pipe = w_rs1_pipe | (r_pipe_v[k] & (r_pipe_addr[k] == issue_rs1_addr_i));
            w_rs2_pipe = w_rs2_pipe | (r_pipe_v[k] & (r_pipe_addr[k] == issue_rs2_addr_i));
            w_rd_pipe  = w_rd_pipe  | (r_pipe_v[k] & (r_pipe_addr[k] == issue_rd_addr_i));
        end
    end

    // A same-cycle long writeback is forwarded by the register file, so it masks busy.
    assign w_rs1_busy = r_busy[issue_rs1_addr_i] & ~(long_wb_v_i & (long_wb_addr_i == issue_rs1_addr_i));
    assign w_rs2_busy = r_busy[issue_rs2_addr_i] & ~(long_wb_v_i & (long_wb_addr_i == issue_rs2_addr_i));
    assign w_rd_busy  = r_busy[issue_rd_addr_i]  & ~(long_wb_v_i & (long_wb_addr_i == issue_rd_addr_i));
    assign w_wb_clr   = long_wb_v_i & r_busy[long_wb_addr_i];

    assign w_rd_nz     = issue_rd_v_i & (issue_rd_addr_i != X0);
    assign w_rd_long_v = w_rd_nz & issue_rd_long_i;
    assign w_rd_fix_v  = w_rd_nz & ~issue_rd_long_i;

    assign w_raw      = (issue_rs1_v_i & (issue_rs1_addr_i != X0) & (w_rs1_pipe | w_rs1_busy))
                      | (issue_rs2_v_i & (issue_rs2_addr_i != X0) & (w_rs2_pipe | w_rs2_busy));
    assign w_waw      = w_rd_nz & w_rd_busy;
    assign w_long_waw = w_rd_long_v & w_rd_pipe;
    assign w_full     = w_rd_long_v & (r_long_cnt == 4'(long_max_p)) & ~w_wb_clr;

    // Reset is folded in so the strobes drop the moment reset asserts.
    assign w_ready  = reset_n_i & ~flush_i & ~w_raw & ~w_waw & ~w_long_waw & ~w_full;
    assign w_accept = issue_v_i & w_ready;

    assign w_long_push = w_accept & w_rd_long_v;
    assign w_fix_push  = w_accept & w_rd_fix_v;

    assign issue_ready_o = w_ready;
    assign rs1_r_v_o     = w_accept & issue_rs1_v_i;
    assign rs2_r_v_o     = w_accept & issue_rs2_v_i;
    assign long_cnt_o    = r_long_cnt;

    // Busy next-state: a new long write to the retiring register keeps it busy.
    always_comb begin
        w_busy_nxt = r_busy;
        for (int r = 0; r < NumRegs; r++) begin
            w_busy_nxt[r] = (r_busy[r] & ~(long_wb_v_i & (long_wb_addr_i == addr_t'(r))))
                          | (w_long_push & (issue_rd_addr_i == addr_t'(r)));
        end
    end

    // Fixed-latency write pipe; the entry leaving the last stage is simply dropped.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_pipe_v <= '0;
            for (int k = 1; k <= NumStages; k++) begin
                r_pipe_addr[k] <= X0;
            end
        end else if (flush_i) begin
            r_pipe_v <= '0;
        end else begin
            r_pipe_v[1]    <= w_fix_push;
            r_pipe_addr[1] <= issue_rd_addr_i;
            for (int k = 2; k <= NumStages; k++) begin
                r_pipe_v[k]    <= r_pipe_v[k-1];
                r_pipe_addr[k] <= r_pipe_addr[k-1];
            end
        end
    end

    // Long-write busy bits survive a flush because committed long operations still return.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_busy <= '0;
        end else begin
            r_busy <= w_busy_nxt;
        end
    end

    // Outstanding long-write counter.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_long_cnt <= 4'd0;
        end else begin
            case ({w_long_push, w_wb_clr})
                2'b10:   r_long_cnt <= r_long_cnt + 4'd1;
                2'b01:   r_long_cnt <= r_long_cnt - 4'd1;
                default: r_long_cnt <= r_long_cnt;
            endcase
        end
    end

endmodule

// File: tb/tb_bp_be_issue_scoreboard.sv
// Self-checking bench for bp_be_issue_scoreboard: per-cycle expectations are queued
// when stimulus is driven and compared against the DUT outputs on the falling edge.
module tb_bp_be_issue_scoreboard;

    logic       clk_i = 1'b0;
    logic       reset_n_i;
    logic       issue_v_i, issue_rs1_v_i, issue_rs2_v_i, issue_rd_v_i, issue_rd_long_i;
    logic [4:0] issue_rs1_addr_i, issue_rs2_addr_i, issue_rd_addr_i, long_wb_addr_i;
    logic       issue_ready_o, rs1_r_v_o, rs2_r_v_o;
    logic       long_wb_v_i, flush_i;
    logic [3:0] long_cnt_o;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        string      tag;
        logic       rdy;
        logic       rs1;
        logic       rs2;
        logic [3:0] cnt;
    } exp_t;

    exp_t exp_q[$];

    bp_be_issue_scoreboard #(
        .reg_addr_width_p(5),
        .pipe_depth_p    (4),
        .long_max_p      (4)
    ) dut (
        .clk_i           (clk_i),
        .reset_n_i       (reset_n_i),
        .issue_v_i       (issue_v_i),
        .issue_rs1_v_i   (issue_rs1_v_i),
        .issue_rs1_addr_i(issue_rs1_addr_i),
        .issue_rs2_v_i   (issue_rs2_v_i),
        .issue_rs2_addr_i(issue_rs2_addr_i),
        .issue_rd_v_i    (issue_rd_v_i),
        .issue_rd_addr_i (issue_rd_addr_i),
        .issue_rd_long_i (issue_rd_long_i),
        .issue_ready_o   (issue_ready_o),
        .rs1_r_v_o       (rs1_r_v_o),
        .rs2_r_v_o       (rs2_r_v_o),
        .long_wb_v_i     (long_wb_v_i),
        .long_wb_addr_i  (long_wb_addr_i),
        .flush_i         (flush_i),
        .long_cnt_o      (long_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Scoreboard consumer: one queued expectation per driven cycle.
    always @(negedge clk_i) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            check({e.tag, ".ready"}, 32'(issue_ready_o), 32'(e.rdy));
            check({e.tag, ".rs1v"},  32'(rs1_r_v_o),     32'(e.rs1));
            check({e.tag, ".rs2v"},  32'(rs2_r_v_o),     32'(e.rs2));
            check({e.tag, ".cnt"},   32'(long_cnt_o),    32'(e.cnt));
        end
    end

    task automatic set_req(input logic v, input logic r1v, input logic [4:0] r1,
                           input logic r2v, input logic [4:0] r2,
                           input logic rdv, input logic [4:0] rd, input logic lng);
        issue_v_i        = v;
        issue_rs1_v_i    = r1v;
        issue_rs1_addr_i = r1;
        issue_rs2_v_i    = r2v;
        issue_rs2_addr_i = r2;
        issue_rd_v_i     = rdv;
        issue_rd_addr_i  = rd;
        issue_rd_long_i  = lng;
    endtask

    task automatic idle();
        set_req(1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
    endtask

    task automatic wb(input logic [4:0] a);
        long_wb_v_i    = 1'b1;
        long_wb_addr_i = a;
    endtask

    // Queue the expectation for the current inputs, then advance one cycle.
    task automatic step(input string tag, input logic exp_rdy, input logic [3:0] exp_cnt);
        exp_t e;
        e.tag = tag;
        e.rdy = exp_rdy;
        e.rs1 = issue_v_i & exp_rdy & issue_rs1_v_i;
        e.rs2 = issue_v_i & exp_rdy & issue_rs2_v_i;
        e.cnt = exp_cnt;
        exp_q.push_back(e);
        @(posedge clk_i);
        #1;
        long_wb_v_i = 1'b0;
        flush_i     = 1'b0;
    endtask

    initial begin
        reset_n_i      = 1'b0;
        long_wb_v_i    = 1'b0;
        long_wb_addr_i = 5'd0;
        flush_i        = 1'b0;
        set_req(1'b1, 1'b1, 5'd1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
        @(posedge clk_i);
        #1;

        step("rst0", 1'b0, 4'd0);
        step("rst1", 1'b0, 4'd0);
        reset_n_i = 1'b1;
        idle();
        step("post_rst", 1'b1, 4'd0);

        // Fixed RAW: x5 written at cycle 0, reader stalls cycles 1-3.
        set_req(1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd5, 1'b0);
        step("fix_w", 1'b1, 4'd0);
        set_req(1'b1, 1'b1, 5'd5, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
        for (int i = 1; i <= 3; i++) step($sformatf("fix_raw_c%0d", i), 1'b0, 4'd0);
        step("fix_raw_c4", 1'b1, 4'd0);

        // Long RAW: x7 long write, reader of rs2 until writeback at cycle 10.
        set_req(1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd7, 1'b1);
        step("long_w", 1'b1, 4'd0);
        set_req(1'b1, 1'b0, 5'd0, 1'b1, 5'd7, 1'b0, 5'd0, 1'b0);
        for (int i = 1; i <= 9; i++) step($sformatf("long_raw_c%0d", i), 1'b0, 4'd1);
        wb(5'd7);
        step("long_raw_c10", 1'b1, 4'd1);
        idle();
        step("long_raw_c11", 1'b1, 4'd0);

        // Writeback to a non-busy register is ignored.
        wb(5'd2);
        step("wb_idle", 1'b1, 4'd0);
        step("wb_idle_after", 1'b1, 4'd0);

        // Full: four outstanding long writes, fifth waits for a clearing writeback.
        for (int i = 1; i <= 4; i++) begin
            set_req(1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 5'(i), 1'b1);
            step($sformatf("full_fill%0d", i), 1'b1, 4'(i - 1));
        end
        set_req(1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd8, 1'b1);
        step("full_stall0", 1'b0, 4'd4);
        step("full_stall1", 1'b0, 4'd4);
        wb(5'd2);
        step("full_wb_acc", 1'b1, 4'd4);
        idle();
        step("full_after", 1'b1, 4'd4);
        wb(5'd1); step("drain1", 1'b1, 4'd4);
        wb(5'd3); step("drain3", 1'b1, 4'd3);
        wb(5'd4); step("drain4", 1'b1, 4'd2);
        wb(5'd8); step("drain8", 1'b1, 4'd1);
        step("drained", 1'b1, 4'd0);

        // WAW: fixed x9 then long x9 stalls through cycle 3.
        set_req(1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd9, 1'b0);
        step("waw1_fix", 1'b1, 4'd0);
        set_req(1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd9, 1'b1);
        for (int i = 1; i <= 3; i++) step($sformatf("waw1_c%0d", i), 1'b0, 4'd0);
        step("waw1_acc", 1'b1, 4'd0);
        // WAW: long x9 busy, fixed x9 waits for the writeback.
        set_req(1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd9, 1'b0);
        for (int i = 0; i < 3; i++) step($sformatf("waw2_s%0d", i), 1'b0, 4'd1);
        wb(5'd9);
        step("waw2_acc", 1'b1, 4'd1);
        idle();
        for (int i = 0; i < 3; i++) step($sformatf("waw2_drain%0d", i), 1'b1, 4'd0);

        // x0 never stalls and never counts.
        set_req(1'b1, 1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 5'd0, 1'b1);
        step("x0_long", 1'b1, 4'd0);
        set_req(1'b1, 1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 5'd0, 1'b0);
        step("x0_fix", 1'b1, 4'd0);
        set_req(1'b1, 1'b1, 5'd0, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0);
        step("x0_read", 1'b1, 4'd0);

        // Flush squashes the fixed x5 write.
        set_req(1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd5, 1'b0);
        step("fl_w", 1'b1, 4'd0);
        set_req(1'b1, 1'b1, 5'd5, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
        flush_i = 1'b1;
        step("fl_c1", 1'b0, 4'd0);
        step("fl_c2", 1'b1, 4'd0);

        // Async reset with busy x3 and pipe x4 in flight.
        set_req(1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd3, 1'b1);
        step("ar_long", 1'b1, 4'd0);
        set_req(1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd4, 1'b0);
        step("ar_fix", 1'b1, 4'd1);
        set_req(1'b1, 1'b1, 5'd3, 1'b1, 5'd4, 1'b0, 5'd0, 1'b0);
        step("ar_stall", 1'b0, 4'd1);
        reset_n_i = 1'b0;
        step("ar_held0", 1'b0, 4'd0);
        step("ar_held1", 1'b0, 4'd0);
        reset_n_i = 1'b1;
        step("ar_rel", 1'b1, 4'd0);
        idle();
        step("ar_idle", 1'b1, 4'd0);

        @(negedge clk_i);
        #1;
        check("queue_drain", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
